// File: rtl/if_id_queue.sv
// IF/ID decoupling queue: DEPTH-entry instruction FIFO plus a registered ID output stage.
// Optional predecode flag per entry is built only when IF_ID_PREDECODE_EN is defined.
module if_id_queue #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              flush_in,
  input  logic              instE_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [INST_W-1:0] inst_in,
  output logic              full_out,
  input  logic              stall_in,
  output logic [ADDR_W-1:0] pc_out,
  output logic [INST_W-1:0] inst_out,
  output logic              valid_out,
  output logic [CNT_W-1:0]  count_out,
  output logic              is_branch_out
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem_pc_q   [DEPTH];
  logic [INST_W-1:0] mem_inst_q [DEPTH];

  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              valid_q, valid_d;

  logic full, empty, push, advance, pop, bypass, wr_en;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign push    = instE_in && !full && !flush_in;
  assign advance = !stall_in && !flush_in;
  assign pop     = advance && !empty;
  // An empty queue hands the incoming instruction straight to the output stage.
  assign bypass  = advance && empty && push;
  assign wr_en   = push && !bypass;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    valid_d  = valid_q;
    if (flush_in) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      pc_d     = '0;
      inst_d   = '0;
      valid_d  = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
      if (advance) begin
        if (pop) begin
          pc_d    = mem_pc_q[rd_ptr_q];
          inst_d  = mem_inst_q[rd_ptr_q];
          valid_d = 1'b1;
        end else if (bypass) begin
          pc_d    = pc_in;
          inst_d  = inst_in;
          valid_d = 1'b1;
        end else begin
          pc_d    = '0;
          inst_d  = '0;
          valid_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      pc_q     <= '0;
      inst_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      valid_q  <= valid_d;
    end
  end

  // Queue storage is not reset; entries are only read after being written.
  always_ff @(posedge clk_in) begin
    if (wr_en) begin
      mem_pc_q[wr_ptr_q]   <= pc_in;
      mem_inst_q[wr_ptr_q] <= inst_in;
    end
  end

`ifdef IF_ID_PREDECODE_EN
  logic mem_br_q [DEPTH];
  logic br_q, br_d;
  logic br_in;

  // Branch, JAL, JALR opcodes.
  assign br_in = (inst_in[6:0] == 7'b1100011) || (inst_in[6:0] == 7'b1101111) ||
                 (inst_in[6:0] == 7'b1100111);

  always_comb begin
    br_d = br_q;
    if (flush_in)    br_d = 1'b0;
    else if (advance) begin
      if (pop)         br_d = mem_br_q[rd_ptr_q];
      else if (bypass) br_d = br_in;
      else             br_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) br_q <= 1'b0;
    else        br_q <= br_d;
  end

  always_ff @(posedge clk_in) begin
    if (wr_en) mem_br_q[wr_ptr_q] <= br_in;
  end

  assign is_branch_out = br_q;
`else
  assign is_branch_out = 1'b0;
`endif

  assign full_out  = full;
  assign count_out = count_q;
  assign pc_out    = pc_q;
  assign inst_out  = inst_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue (default DEPTH=4).
module tb_if_id_queue;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk_in = 1'b0;
  logic              rst_in;
  logic              flush_in;
  logic              instE_in;
  logic [ADDR_W-1:0] pc_in;
  logic [INST_W-1:0] inst_in;
  logic              full_out;
  logic              stall_in;
  logic [ADDR_W-1:0] pc_out;
  logic [INST_W-1:0] inst_out;
  logic              valid_out;
  logic [CNT_W-1:0]  count_out;
  logic              is_branch_out;

  int total = 0;
  int bad   = 0;

`ifdef IF_ID_PREDECODE_EN
  localparam logic BR_EXP = 1'b1;
`else
  localparam logic BR_EXP = 1'b0;
`endif

  if_id_queue #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .flush_in(flush_in), .instE_in(instE_in),
    .pc_in(pc_in), .inst_in(inst_in), .full_out(full_out), .stall_in(stall_in),
    .pc_out(pc_out), .inst_out(inst_out), .valid_out(valid_out),
    .count_out(count_out), .is_branch_out(is_branch_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, take one rising edge, sample 1 time unit later.
  task automatic cyc(input logic e, input logic [31:0] pc, input logic [31:0] inst,
                     input logic st, input logic fl);
    instE_in = e; pc_in = pc; inst_in = inst; stall_in = st; flush_in = fl;
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                         input logic v, input int cnt);
    chk({tag, ".pc"},    64'(pc_out),    64'(pc));
    chk({tag, ".inst"},  64'(inst_out),  64'(inst));
    chk({tag, ".valid"}, 64'(valid_out), 64'(v));
    chk({tag, ".count"}, 64'(count_out), 64'(cnt));
  endtask

  initial begin
    rst_in = 1'b1; flush_in = 1'b0; instE_in = 1'b0; stall_in = 1'b0;
    pc_in = '0; inst_in = '0;
    #12;
    chk_out("reset", 32'h0, 32'h0, 1'b0, 0);
    chk("reset.full", 64'(full_out), 64'd0);
    chk("reset.br", 64'(is_branch_out), 64'd0);
    rst_in = 1'b0;

    // Bypass into empty queue, then a bubble when nothing is pushed.
    cyc(1, 32'h100, 32'h13, 0, 0);
    chk_out("bypass", 32'h100, 32'h13, 1'b1, 0);
    cyc(0, 32'h0, 32'h0, 0, 0);
    chk_out("bubble0", 32'h0, 32'h0, 1'b0, 0);

    // Fill while stalled; output holds the bubble.
    for (int i = 0; i < 4; i++) cyc(1, 32'(i * 4), 32'hA000_0000 + 32'(i * 4), 1, 0);
    chk_out("fill", 32'h0, 32'h0, 1'b0, 4);
    chk("fill.full", 64'(full_out), 64'd1);
    cyc(1, 32'h10, 32'hA000_0010, 1, 0);
    chk("drop.count", 64'(count_out), 64'd4);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 32'h0, 32'h0, 0, 0);
      chk_out($sformatf("drain%0d", i), 32'(i * 4), 32'hA000_0000 + 32'(i * 4), 1'b1, 3 - i);
    end
    chk("drain.full", 64'(full_out), 64'd0);
    cyc(0, 32'h0, 32'h0, 0, 0);
    chk_out("drain.bubble", 32'h0, 32'h0, 1'b0, 0);

    // Simultaneous push/pop with pointer wrap.
    cyc(1, 32'h20, 32'hB20, 1, 0);
    cyc(1, 32'h24, 32'hB24, 1, 0);
    chk("pp.pre", 64'(count_out), 64'd2);
    cyc(1, 32'h28, 32'hB28, 0, 0);
    chk_out("pp0", 32'h20, 32'hB20, 1'b1, 2);
    cyc(1, 32'h2C, 32'hB2C, 0, 0);
    chk_out("pp1", 32'h24, 32'hB24, 1'b1, 2);
    cyc(1, 32'h30, 32'hB30, 0, 0);
    chk_out("pp2", 32'h28, 32'hB28, 1'b1, 2);
    cyc(0, 32'h0, 32'h0, 0, 0);
    chk_out("pp3", 32'h2C, 32'hB2C, 1'b1, 1);
    cyc(0, 32'h0, 32'h0, 0, 0);
    chk_out("wrap", 32'h30, 32'hB30, 1'b1, 0);

    // Stall hold, then flush with a concurrent push.
    cyc(1, 32'h3C, 32'hC3C, 1, 0);
    cyc(1, 32'h40, 32'hC40, 1, 0);
    cyc(1, 32'h44, 32'hC44, 1, 0);
    chk_out("hold", 32'h30, 32'hB30, 1'b1, 3);
    cyc(1, 32'h4C, 32'hC4C, 1, 1);
    chk_out("flush", 32'h0, 32'h0, 1'b0, 0);
    cyc(0, 32'h0, 32'h0, 0, 0);
    chk_out("flush.after", 32'h0, 32'h0, 1'b0, 0);

    // Predecode flag follows the instruction.
    cyc(1, 32'h200, 32'h0000006F, 0, 0);
    chk_out("pd.jal", 32'h200, 32'h6F, 1'b1, 0);
    chk("pd.jal.br", 64'(is_branch_out), 64'(BR_EXP));
    cyc(1, 32'h204, 32'h00000013, 0, 0);
    chk("pd.addi.br", 64'(is_branch_out), 64'd0);

    // Asynchronous reset mid-operation.
    cyc(1, 32'h300, 32'hD00, 1, 0);
    cyc(1, 32'h304, 32'hD04, 1, 0);
    cyc(1, 32'h308, 32'hD08, 1, 0);
    chk("mid.count", 64'(count_out), 64'd3);
    instE_in = 1'b0;
    #2 rst_in = 1'b1;
    #1;
    chk_out("midrst", 32'h0, 32'h0, 1'b0, 0);
    chk("midrst.br", 64'(is_branch_out), 64'd0);
    chk("midrst.full", 64'(full_out), 64'd0);
    #3 rst_in = 1'b0;
    cyc(0, 32'h0, 32'h0, 0, 0);
    chk_out("postrst", 32'h0, 32'h0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
